// File: rtl/parity_pkg.sv
// Shared definitions for the parity receive checker: parity sense constants
// and the burst-alarm state encoding.
package parity_pkg;

    localparam logic PARITY_ODD  = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;

    typedef enum logic [1:0] {
        BURST_IDLE  = 2'd0,
        BURST_RUN   = 2'd1,
        BURST_ALARM = 2'd2
    } burst_state_t;

endpackage

// File: rtl/parity_burst_fsm.sv
// Consecutive-error tracker: raises burst_alarm after ERR_BURST errored words
// in a row and holds it until err_clr.
module parity_burst_fsm
    import parity_pkg::*;
#(
    parameter int ERR_BURST = 4,
    parameter int RUN_W     = $clog2(ERR_BURST + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic word_acc,
    input  logic word_err,
    input  logic err_clr,
    output logic burst_alarm
);

    burst_state_t     state_reg, state_next;
    logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;

    // Effective starting point for this cycle: a clear restarts the tracker,
    // but an errored word in the same cycle is still counted from IDLE.
    burst_state_t     base_state;
    logic [RUN_W-1:0] base_run;
    logic [RUN_W-1:0] run_inc;

    always_comb begin
        base_state   = err_clr ? BURST_IDLE : state_reg;
        base_run     = err_clr ? '0 : run_cnt_reg;
        run_inc      = base_run + RUN_W'(1);
        state_next   = base_state;
        run_cnt_next = base_run;

        if (word_acc) begin
            case (base_state)
                BURST_IDLE: begin
                    if (word_err) begin
                        run_cnt_next = RUN_W'(1);
                        state_next   = (ERR_BURST == 1) ? BURST_ALARM : BURST_RUN;
                    end
                end
                BURST_RUN: begin
                    if (word_err) begin
                        run_cnt_next = run_inc;
                        state_next   = (run_inc == RUN_W'(ERR_BURST)) ? BURST_ALARM : BURST_RUN;
                    end else begin
                        run_cnt_next = '0;
                        state_next   = BURST_IDLE;
                    end
                end
                BURST_ALARM: begin
                    state_next = BURST_ALARM;
                end
                default: begin
                    state_next   = BURST_IDLE;
                    run_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= BURST_IDLE;
            run_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            run_cnt_reg <= run_cnt_next;
        end
    end

    assign burst_alarm = (state_reg == BURST_ALARM);

endmodule

// File: rtl/parity_check.sv
// Receive-side parity checker: strips the parity MSB, forwards the payload
// through a one-deep output register and keeps error statistics.
module parity_check
    import parity_pkg::*;
#(
    parameter int   DATA_WIDTH  = 8,
    parameter logic PARITY_TYPE = PARITY_ODD,
    parameter int   ERR_CNT_W   = 16,
    parameter int   ERR_BURST   = 4,
    parameter logic DROP_ERR    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err,
    output logic                  err_sticky,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic                  burst_alarm,
    input  logic                  err_clr
);

    logic                  out_valid_reg, out_valid_next;
    logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic                  out_err_reg, out_err_next;
    logic                  err_sticky_reg, err_sticky_next;
    logic [ERR_CNT_W-1:0]  err_cnt_reg, err_cnt_next;

    logic word_err;
    logic word_acc;
    logic word_fwd;

    assign word_err = (^in_data) ^ PARITY_TYPE ^ 1'b1;
    assign in_ready = ~out_valid_reg | out_ready;
    assign word_acc = in_valid & in_ready;
    // Dropped words are consumed without occupying the output register.
    assign word_fwd = word_acc & ~(DROP_ERR & word_err);

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_err_next   = out_err_reg;
        if (word_fwd) begin
            out_valid_next = 1'b1;
            out_data_next  = in_data[DATA_WIDTH-1:0];
            out_err_next   = word_err;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // An errored word arriving with err_clr restarts the count at one.
    always_comb begin
        err_cnt_next    = err_cnt_reg;
        err_sticky_next = err_sticky_reg;
        if (word_acc && word_err) begin
            err_sticky_next = 1'b1;
            if (err_clr) begin
                err_cnt_next = ERR_CNT_W'(1);
            end else if (~&err_cnt_reg) begin
                err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            err_cnt_next    = '0;
            err_sticky_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_err_reg    <= 1'b0;
            err_sticky_reg <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_err_reg    <= out_err_next;
            err_sticky_reg <= err_sticky_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    parity_burst_fsm #(
        .ERR_BURST (ERR_BURST)
    ) u_burst (
        .clk         (clk),
        .rstn        (rstn),
        .word_acc    (word_acc),
        .word_err    (word_err),
        .err_clr     (err_clr),
        .burst_alarm (burst_alarm)
    );

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_err    = out_err_reg;
    assign err_sticky = err_sticky_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_parity_check.sv
// Directed bench for parity_check: odd, even and drop-errored instances share
// one stimulus stream; table vectors plus hand-written corner sequences.
module tb_parity_check;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_valid = 1'b0;
    logic [8:0] in_data = '0;
    logic       out_ready = 1'b1;
    logic       err_clr = 1'b0;

    logic       o_in_ready, o_out_valid, o_out_err, o_err_sticky, o_burst;
    logic [7:0] o_out_data;
    logic [3:0] o_err_cnt;
    logic       e_in_ready, e_out_valid, e_out_err, e_err_sticky, e_burst;
    logic [7:0] e_out_data;
    logic [3:0] e_err_cnt;
    logic       d_in_ready, d_out_valid, d_out_err, d_err_sticky, d_burst;
    logic [7:0] d_out_data;
    logic [3:0] d_err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_check #(.DATA_WIDTH(8), .PARITY_TYPE(1'b0), .ERR_CNT_W(4), .ERR_BURST(4), .DROP_ERR(1'b0)) dut_odd (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(o_in_ready), .in_data(in_data),
        .out_valid(o_out_valid), .out_ready(out_ready), .out_data(o_out_data), .out_err(o_out_err),
        .err_sticky(o_err_sticky), .err_cnt(o_err_cnt), .burst_alarm(o_burst), .err_clr(err_clr));

    parity_check #(.DATA_WIDTH(8), .PARITY_TYPE(1'b1), .ERR_CNT_W(4), .ERR_BURST(4), .DROP_ERR(1'b0)) dut_even (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(e_in_ready), .in_data(in_data),
        .out_valid(e_out_valid), .out_ready(out_ready), .out_data(e_out_data), .out_err(e_out_err),
        .err_sticky(e_err_sticky), .err_cnt(e_err_cnt), .burst_alarm(e_burst), .err_clr(err_clr));

    parity_check #(.DATA_WIDTH(8), .PARITY_TYPE(1'b0), .ERR_CNT_W(4), .ERR_BURST(4), .DROP_ERR(1'b1)) dut_drop (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
        .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data), .out_err(d_out_err),
        .err_sticky(d_err_sticky), .err_cnt(d_err_cnt), .burst_alarm(d_burst), .err_clr(err_clr));

    typedef struct {
        logic [8:0] din;
        logic       err_odd;
        logic       err_even;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        err_clr   = 1'b0;
        out_ready = 1'b1;
        rstn      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Presents one word for one clock and returns 1 time unit after the edge.
    task automatic send(input logic [8:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        int cnt_odd, cnt_even, xfers;

        vecs[0] = '{9'h100, 1'b0, 1'b1};
        vecs[1] = '{9'h003, 1'b1, 1'b0};
        vecs[2] = '{9'h101, 1'b1, 1'b0};
        vecs[3] = '{9'h103, 1'b0, 1'b1};
        vecs[4] = '{9'h0FF, 1'b1, 1'b0};
        vecs[5] = '{9'h1FF, 1'b0, 1'b1};
        vecs[6] = '{9'h000, 1'b1, 1'b0};
        vecs[7] = '{9'h0A5, 1'b1, 1'b0};
        vecs[8] = '{9'h15A, 1'b0, 1'b1};

        // Reset state
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_out_err", o_out_err, 0);
        chk("rst_sticky", o_err_sticky, 0);
        chk("rst_err_cnt", o_err_cnt, 0);
        chk("rst_burst", o_burst, 0);
        chk("rst_in_ready", o_in_ready, 1);
        do_reset();

        // Table vectors, back to back at full throughput
        cnt_odd  = 0;
        cnt_even = 0;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].din);
            cnt_odd  += int'(vecs[i].err_odd);
            cnt_even += int'(vecs[i].err_even);
            $display("vec %0d din=%03h odd: data=%02h err=%0b cnt=%0d even: err=%0b cnt=%0d",
                     i, vecs[i].din, o_out_data, o_out_err, o_err_cnt, e_out_err, e_err_cnt);
            chk("odd_valid", o_out_valid, 1);
            chk("odd_data", o_out_data, {24'd0, vecs[i].din[7:0]});
            chk("odd_err", o_out_err, vecs[i].err_odd);
            chk("odd_cnt", o_err_cnt, cnt_odd);
            chk("even_data", e_out_data, {24'd0, vecs[i].din[7:0]});
            chk("even_err", e_out_err, vecs[i].err_even);
            chk("even_cnt", e_err_cnt, cnt_even);
            chk("drop_valid", d_out_valid, !vecs[i].err_odd);
            chk("drop_cnt", d_err_cnt, cnt_odd);
        end
        chk("odd_sticky", o_err_sticky, 1);
        chk("even_sticky", e_err_sticky, 1);
        chk("odd_burst_idle", o_burst, 0);
        chk("even_burst_idle", e_burst, 0);
        @(posedge clk);
        #1 chk("drain_valid", o_out_valid, 0);

        // Backpressure: one word held, input stalled, then full rate on release
        do_reset();
        out_ready = 1'b0;
        in_data   = 9'h100;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_data = 9'h1AA;
        for (int c = 0; c < 5; c++) begin
            $display("bp cycle %0d valid=%0b data=%02h in_ready=%0b", c, o_out_valid, o_out_data, o_in_ready);
            chk("bp_valid", o_out_valid, 1);
            chk("bp_data", o_out_data, 8'h00);
            chk("bp_in_ready", o_in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", o_in_ready, 1);
        @(posedge clk);
        #1 chk("bp_next_data", o_out_data, 8'hAA);
        send(9'h155);
        chk("bp_rate_data", o_out_data, 8'h55);
        chk("bp_rate_valid", o_out_valid, 1);
        @(posedge clk);
        #1 chk("bp_drain", o_out_valid, 0);

        // Burst: 3 errors, good, 4 errors, good, clear
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send(9'h003);
            chk("burst_pre", o_burst, 0);
        end
        send(9'h100);
        chk("burst_after_good", o_burst, 0);
        for (int k = 1; k <= 4; k++) begin
            send(9'h003);
            $display("burst err %0d alarm=%0b cnt=%0d", k, o_burst, o_err_cnt);
            chk("burst_run", o_burst, (k == 4) ? 1 : 0);
        end
        send(9'h100);
        chk("burst_good_holds", o_burst, 1);
        chk("burst_cnt", o_err_cnt, 7);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        chk("burst_clr_alarm", o_burst, 0);
        chk("burst_clr_cnt", o_err_cnt, 0);
        chk("burst_clr_sticky", o_err_sticky, 0);

        // Saturation and clear/error race
        do_reset();
        for (int k = 0; k < 20; k++) send(9'h003);
        $display("sat cnt=%0d sticky=%0b alarm=%0b", o_err_cnt, o_err_sticky, o_burst);
        chk("sat_cnt", o_err_cnt, 4'hF);
        chk("sat_burst", o_burst, 1);
        err_clr = 1'b1;
        send(9'h003);
        err_clr = 1'b0;
        chk("race_cnt", o_err_cnt, 1);
        chk("race_sticky", o_err_sticky, 1);
        chk("race_burst", o_burst, 0);
        chk("race_data", o_out_data, 8'h03);
        err_clr = 1'b1;
        send(9'h100);
        err_clr = 1'b0;
        chk("clr_good_cnt", o_err_cnt, 0);
        chk("clr_good_sticky", o_err_sticky, 0);

        // Drop errored words: good, bad, good
        do_reset();
        xfers = 0;
        send(9'h100);
        if (d_out_valid) xfers++;
        send(9'h003);
        if (d_out_valid) xfers++;
        send(9'h1FF);
        if (d_out_valid) xfers++;
        chk("drop_last_data", d_out_data, 8'hFF);
        chk("drop_out_err", d_out_err, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 if (d_out_valid) xfers++;
        end
        $display("drop xfers=%0d cnt=%0d", xfers, d_err_cnt);
        chk("drop_xfers", xfers, 2);
        chk("drop_err_cnt", d_err_cnt, 1);

        // Async reset with a word held under backpressure
        out_ready = 1'b0;
        send(9'h003);
        chk("hold_odd_err", o_out_err, 1);
        chk("hold_odd_valid", o_out_valid, 1);
        chk("hold_drop_cnt", d_err_cnt, 2);
        #3 rstn = 1'b0;
        #1;
        $display("async rst odd valid=%0b data=%02h err=%0b drop cnt=%0d", o_out_valid, o_out_data, o_out_err, d_err_cnt);
        chk("arst_odd_valid", o_out_valid, 0);
        chk("arst_odd_data", o_out_data, 0);
        chk("arst_odd_err", o_out_err, 0);
        chk("arst_odd_cnt", o_err_cnt, 0);
        chk("arst_drop_cnt", d_err_cnt, 0);
        chk("arst_drop_sticky", d_err_sticky, 0);
        chk("arst_drop_valid", d_out_valid, 0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
